// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator (I/S/B/J/U/Z) with a registered valid/ready output and a skid register.
// One cycle latency; in_ready depends only on registered state, so there is no out_ready-to-in_ready path.
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 5,
    parameter int AUTO_DECODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [2:0] SRC_I   = 3'd0;
    localparam logic [2:0] SRC_S   = 3'd1;
    localparam logic [2:0] SRC_B   = 3'd2;
    localparam logic [2:0] SRC_J   = 3'd3;
    localparam logic [2:0] SRC_U   = 3'd4;
    localparam logic [2:0] SRC_Z   = 3'd5;
    localparam logic [2:0] SRC_BAD = 3'd6;

    logic [2:0]         w_src;
    logic signed [11:0] w_fld_i;
    logic signed [11:0] w_fld_s;
    logic signed [12:0] w_fld_b;
    logic signed [20:0] w_fld_j;
    logic signed [31:0] w_fld_u;
    logic [XLEN-1:0]    w_imm;
    logic               w_ill;
    logic               w_push;
    logic               w_pop;

    logic               r_or_vld;
    logic [XLEN-1:0]    r_or_imm;
    logic               r_or_ill;
    logic [TAG_W-1:0]   r_or_tag;
    logic               r_sr_vld;
    logic [XLEN-1:0]    r_sr_imm;
    logic               r_sr_ill;
    logic [TAG_W-1:0]   r_sr_tag;

    always_comb begin
        w_src = in_imm_src;
        if (AUTO_DECODE != 0) begin
            case (in_instr[6:0])
                7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: w_src = SRC_I;
                7'b0100011:             w_src = SRC_S;
                7'b1100011:             w_src = SRC_B;
                7'b1101111:             w_src = SRC_J;
                7'b0110111, 7'b0010111: w_src = SRC_U;
                // Only the immediate CSR forms carry a zimm in rs1.
                7'b1110011:             w_src = in_instr[14] ? SRC_Z : SRC_BAD;
                default:                w_src = SRC_BAD;
            endcase
        end
    end

    assign w_fld_i = in_instr[31:20];
    assign w_fld_s = {in_instr[31:25], in_instr[11:7]};
    assign w_fld_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_fld_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign w_fld_u = {in_instr[31:12], 12'b0};

    // Signed fields widen with sign extension through the size cast.
    always_comb begin
        w_imm = '0;
        w_ill = 1'b0;
        case (w_src)
            SRC_I:   w_imm = XLEN'(w_fld_i);
            SRC_S:   w_imm = XLEN'(w_fld_s);
            SRC_B:   w_imm = XLEN'(w_fld_b);
            SRC_J:   w_imm = XLEN'(w_fld_j);
            SRC_U:   w_imm = XLEN'(w_fld_u);
            SRC_Z:   w_imm = XLEN'(in_instr[19:15]);
            default: w_ill = 1'b1;
        endcase
    end

    assign in_ready = !r_sr_vld && !reset;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = r_or_vld && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_or_vld <= 1'b0;
            r_or_imm <= '0;
            r_or_ill <= 1'b0;
            r_or_tag <= '0;
            r_sr_vld <= 1'b0;
            r_sr_imm <= '0;
            r_sr_ill <= 1'b0;
            r_sr_tag <= '0;
        end else if (flush) begin
            r_or_vld <= 1'b0;
            r_sr_vld <= 1'b0;
        end else if (r_sr_vld && w_pop) begin
            r_or_imm <= r_sr_imm;
            r_or_ill <= r_sr_ill;
            r_or_tag <= r_sr_tag;
            r_sr_vld <= 1'b0;
        end else if (w_push && (!r_or_vld || w_pop)) begin
            r_or_vld <= 1'b1;
            r_or_imm <= w_imm;
            r_or_ill <= w_ill;
            r_or_tag <= in_tag;
        end else if (w_push) begin
            r_sr_vld <= 1'b1;
            r_sr_imm <= w_imm;
            r_sr_ill <= w_ill;
            r_sr_tag <= in_tag;
        end else if (w_pop) begin
            r_or_vld <= 1'b0;
        end
    end

    assign out_valid   = r_or_vld;
    assign out_imm     = r_or_imm;
    assign out_illegal = r_or_ill;
    assign out_tag     = r_or_tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: 32-bit manual-select instance scored through a queue, plus a 64-bit
// auto-decode instance checked directly on the cycle after each accepted beat.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [4:0]  in_tag;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm;
    logic [4:0]  out_tag;
    logic        ax_in_ready, ax_out_valid, ax_out_illegal;
    logic [63:0] ax_out_imm;
    logic [4:0]  ax_out_tag;
    logic        ax_out_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] imm;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;
    exp_t sb[$];

    logic        h_vld = 1'b0;
    logic [31:0] h_imm;
    logic [4:0]  h_tag;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .AUTO_DECODE(0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .AUTO_DECODE(1)) dut_ax (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ax_in_ready), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(ax_out_valid), .out_ready(ax_out_ready), .out_imm(ax_out_imm),
        .out_illegal(ax_out_illegal), .out_tag(ax_out_tag)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop and hold-stability check, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && h_vld) begin
            chk("hold_valid", {63'b0, out_valid}, 64'd1);
            chk("hold_imm", {32'b0, out_imm}, {32'b0, h_imm});
            chk("hold_tag", {59'b0, out_tag}, {59'b0, h_tag});
        end
        h_vld = !reset && !flush && out_valid && !out_ready;
        h_imm = out_imm;
        h_tag = out_tag;
        if (!reset && out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL pop_unexpected observed tag=%h expected no beat", out_tag);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("pop_imm", {32'b0, out_imm}, {32'b0, e.imm});
                chk("pop_illegal", {63'b0, out_illegal}, {63'b0, e.ill});
                chk("pop_tag", {59'b0, out_tag}, {59'b0, e.tag});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [2:0] src, input logic [4:0] tg,
                        input logic [31:0] ei, input logic el);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            out_ready = 1'b1;
            step();
            n++;
        end
        chk("send_ready", {63'b0, in_ready}, 64'd1);
        in_valid   = 1'b1;
        in_instr   = ins;
        in_imm_src = src;
        in_tag     = tg;
        sb.push_back('{imm: ei, ill: el, tag: tg});
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] ri;
        logic        rz;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_imm_src = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {63'b0, in_ready}, 64'd0);
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_out_imm", {32'b0, out_imm}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        step();
        chk("post_reset_in_ready", {63'b0, in_ready}, 64'd1);
        chk("post_reset_tag", {59'b0, out_tag}, 64'd0);

        // I type; 64-bit auto instance sees opcode 0010011 as I as well.
        send(32'hFFF00093, 3'd0, 5'd3, 32'hFFFFFFFF, 1'b0);
        chk("latency_out_valid", {63'b0, out_valid}, 64'd1);
        chk("ax_i_imm", ax_out_imm, 64'hFFFFFFFFFFFFFFFF);
        send(32'hFE112E23, 3'd1, 5'd4, 32'hFFFFFFFC, 1'b0);
        chk("ax_s_imm", ax_out_imm, 64'hFFFFFFFFFFFFFFFC);
        send(32'hFE000CE3, 3'd2, 5'd5, 32'hFFFFFFF8, 1'b0);
        chk("ax_b_imm", ax_out_imm, 64'hFFFFFFFFFFFFFFF8);
        send(32'h0010006F, 3'd3, 5'd6, 32'h00000800, 1'b0);
        chk("ax_j_imm", ax_out_imm, 64'h0000000000000800);
        send(32'h800002B7, 3'd4, 5'd7, 32'h80000000, 1'b0);
        chk("ax_u_imm", ax_out_imm, 64'hFFFFFFFF80000000);
        send(32'h340FD073, 3'd5, 5'd8, 32'h0000001F, 1'b0);
        chk("ax_z_imm", ax_out_imm, 64'h000000000000001F);
        send(32'hFFF00093, 3'd6, 5'd9, 32'h00000000, 1'b1);
        send(32'h0000007F, 3'd0, 5'd10, 32'h00000000, 1'b0);
        chk("ax_bad_illegal", {63'b0, ax_out_illegal}, 64'd1);
        chk("ax_bad_imm", ax_out_imm, 64'd0);
        chk("ax_bad_tag", {59'b0, ax_out_tag}, 64'd10);
        send(32'h00002073, 3'd7, 5'd11, 32'h00000000, 1'b1);
        chk("ax_csr_reg_illegal", {63'b0, ax_out_illegal}, 64'd1);
        drain();

        // Backpressure: two beats fill OR and SR, then release in order.
        out_ready = 1'b0;
        send(32'h00100093, 3'd0, 5'd1, 32'h00000001, 1'b0);
        send(32'h00200093, 3'd0, 5'd2, 32'h00000002, 1'b0);
        chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
        step();
        chk("bp_or_tag", {59'b0, out_tag}, 64'd1);
        drain();

        // Flush with both registers full and a beat presented.
        out_ready = 1'b0;
        send(32'h00300093, 3'd0, 5'd3, 32'h00000003, 1'b0);
        send(32'h00400093, 3'd0, 5'd4, 32'h00000004, 1'b0);
        in_valid = 1'b1; in_instr = 32'h00500093; in_tag = 5'd5; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // A beat accepted in a flush cycle must not emerge.
        in_valid = 1'b1; in_instr = 32'h00600093; in_tag = 5'd6; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_push_dropped", {63'b0, out_valid}, 64'd0);
        repeat (3) step();

        // Randomised stream with varying backpressure, I and Z types.
        for (int i = 0; i < 24; i++) begin
            ri = $urandom;
            rz = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            if (rz) send(ri, 3'd5, 5'(i), {27'b0, ri[19:15]}, 1'b0);
            else    send(ri, 3'd0, 5'(i), {{20{ri[31]}}, ri[31:20]}, 1'b0);
        end
        drain();

        // Reset mid-stream drops everything.
        out_ready = 1'b0;
        send(32'hFFF00093, 3'd0, 5'd21, 32'hFFFFFFFF, 1'b0);
        send(32'hFFF00093, 3'd1, 5'd22, 32'hFFFFFFE1, 1'b0);
        reset = 1'b1;
        step();
        sb.delete();
        chk("mid_reset_valid", {63'b0, out_valid}, 64'd0);
        chk("mid_reset_imm", {32'b0, out_imm}, 64'd0);
        chk("mid_reset_illegal", {63'b0, out_illegal}, 64'd0);
        chk("mid_reset_tag", {59'b0, out_tag}, 64'd0);
        chk("mid_reset_in_ready", {63'b0, in_ready}, 64'd0);
        chk("mid_reset_ax_imm", ax_out_imm, 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_mid_reset_in_ready", {62'b0, in_ready, ax_in_ready}, 64'd3);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
